// File: rtl/snitch_fpu_rob.sv
//------------------------------------------------------------------------------
// snitch_fpu_rob: tags FPU requests and retires out-of-order results in issue order.
// Optional same-cycle result forwarding to writeback: SNITCH_FPU_ROB_BYPASS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module snitch_fpu_rob #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned FLEN       = 64,
  parameter int unsigned RdWidth    = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [RdWidth-1:0] issue_rd_i,
  output logic               fpu_in_valid_o,
  input  logic               fpu_in_ready_i,
  output logic [7:0]         fpu_tag_o,
  input  logic               fpu_out_valid_i,
  output logic               fpu_out_ready_o,
  input  logic [FLEN-1:0]    fpu_result_i,
  input  logic [4:0]         fpu_status_i,
  input  logic [7:0]         fpu_tag_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [RdWidth-1:0] wb_rd_o,
  output logic [FLEN-1:0]    wb_data_o,
  output logic [4:0]         fflags_o,
  input  logic               fflags_clr_i,
  output logic               busy_o,
  output logic               tag_err_o
);

  localparam int unsigned IdxW = $clog2(NumEntries);
  localparam int unsigned PtrW = IdxW + 1;

  logic [NumEntries-1:0] alloc_q, alloc_d, done_q, done_d;
  logic [RdWidth-1:0]    rd_q     [NumEntries];
  logic [FLEN-1:0]       result_q [NumEntries];
  logic [4:0]            status_q [NumEntries];
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [4:0]            fflags_q, fflags_d;
  logic                  tag_err_q, tag_err_d;

  logic [IdxW-1:0] head_idx, tail_idx, cap_idx;
  logic            full, empty, tag_hi_ok, cap_ok, cap_err, cap_store;
  logic            issue_fire, wb_fire, bypass;
  logic [4:0]      retire_status;

  assign head_idx = head_q[IdxW-1:0];
  assign tail_idx = tail_q[IdxW-1:0];
  assign cap_idx  = fpu_tag_i[IdxW-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);
  assign empty    = (head_q == tail_q);

  generate
    if (IdxW < 8) begin : g_tag_hi
      assign tag_hi_ok = (fpu_tag_i[7:IdxW] == '0);
    end else begin : g_tag_full
      assign tag_hi_ok = 1'b1;
    end
  endgenerate

  assign cap_ok     = fpu_out_valid_i && tag_hi_ok && alloc_q[cap_idx] && !done_q[cap_idx];
  assign cap_err    = fpu_out_valid_i && !cap_ok;
  assign issue_fire = issue_valid_i && fpu_in_ready_i && !full;

`ifdef SNITCH_FPU_ROB_BYPASS_EN
  // Forward a result aimed at the pending head straight to writeback.
  assign bypass        = cap_ok && (cap_idx == head_idx);
  assign wb_data_o     = bypass ? fpu_result_i : result_q[head_idx];
  assign retire_status = bypass ? fpu_status_i : status_q[head_idx];
`else
  assign bypass        = 1'b0;
  assign wb_data_o     = result_q[head_idx];
  assign retire_status = status_q[head_idx];
`endif

  assign wb_valid_o = bypass || (alloc_q[head_idx] && done_q[head_idx]);
  assign wb_rd_o    = rd_q[head_idx];
  assign wb_fire    = wb_valid_o && wb_ready_i;
  assign cap_store  = cap_ok && !(bypass && wb_ready_i);

  assign issue_ready_o   = fpu_in_ready_i && !full;
  assign fpu_in_valid_o  = issue_valid_i && !full;
  assign fpu_tag_o       = 8'(tail_idx);
  assign fpu_out_ready_o = 1'b1;
  assign busy_o          = !empty;
  assign fflags_o        = fflags_q;
  assign tag_err_o       = tag_err_q;

  // Issue and retire never touch the same slot: tail==head index only when full or empty.
  always_comb begin
    alloc_d   = alloc_q;
    done_d    = done_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fflags_d  = fflags_q;
    tag_err_d = tag_err_q | cap_err;
    if (cap_store) done_d[cap_idx] = 1'b1;
    if (wb_fire) begin
      alloc_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + PtrW'(1);
    end
    if (issue_fire) begin
      alloc_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + PtrW'(1);
    end
    if (fflags_clr_i) fflags_d = '0;
    if (wb_fire) fflags_d = fflags_d | retire_status;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q   <= '0;
      done_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fflags_q  <= '0;
      tag_err_q <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      done_q    <= done_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fflags_q  <= fflags_d;
      tag_err_q <= tag_err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumEntries); i++) begin
        rd_q[i]     <= '0;
        result_q[i] <= '0;
        status_q[i] <= '0;
      end
    end else begin
      if (issue_fire) rd_q[tail_idx] <= issue_rd_i;
      if (cap_store) begin
        result_q[cap_idx] <= fpu_result_i;
        status_q[cap_idx] <= fpu_status_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/snitch_fpu_rob.md
Name: snitch_fpu_rob

Overview:
- Issue-side companion to the FPU synthesis wrapper: allocates 8-bit tags for outgoing FPU requests, captures results returning possibly out of order (different op groups/latencies), and retires them to the FP register-file writeback port in strict issue order.
- Accumulates sticky fflags from retired ops.
- Operand/opcode payload travels beside this block; only handshake, tag, destination and result pass through it.

Parameters:
- NumEntries, 4, reorder depth; power of two, 2..256.
- FLEN, 64, result width in bits.
- RdWidth, 5, destination register address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  core presents FPU op
- issue_ready_o  out  1  op accepted (FPU ready and ROB not full)
- issue_rd_i  in  RdWidth  destination register of the op
- fpu_in_valid_o  out  1  to FPU in_valid_i
- fpu_in_ready_i  in  1  from FPU in_ready_o
- fpu_tag_o  out  8  to FPU tag_i
- fpu_out_valid_i  in  1  from FPU out_valid_o
- fpu_out_ready_o  out  1  to FPU out_ready_i
- fpu_result_i  in  FLEN  from FPU result_o
- fpu_status_i  in  5  from FPU status_o
- fpu_tag_i  in  8  from FPU tag_o
- wb_valid_o  out  1  in-order writeback valid
- wb_ready_i  in  1  regfile accepts writeback
- wb_rd_o  out  RdWidth  writeback destination
- wb_data_o  out  FLEN  writeback data
- fflags_o  out  5  sticky accumulated status flags
- fflags_clr_i  in  1  clear fflags
- busy_o  out  1  any entry allocated
- tag_err_o  out  1  sticky: result with unallocated or already-done tag

Behaviour:
- Storage: NumEntries entries {alloc, done, rd, result, status}; head/tail pointers of log2(NumEntries)+1 bits (wrap bit); full = same index, different wrap bit; empty = pointers equal.
- Reset: all alloc/done cleared, head=tail=0, fflags_o=0, tag_err_o=0; hence issue_ready_o=fpu_in_ready_i, wb_valid_o=0, busy_o=0. Reset mid-operation discards all in-flight entries; late FPU results then raise tag_err_o.
- Issue: fpu_in_valid_o = issue_valid_i && !full; issue_ready_o = fpu_in_ready_i && !full; fpu_tag_o = tail index zero-extended to 8 bits. On issue handshake: entry[tail] <= {alloc=1, done=0, rd=issue_rd_i}; tail++ (wraps with wrap-bit toggle). No combinational path from issue_valid_i to issue_ready_o.
- Result capture: fpu_out_ready_o = 1 always (slot pre-reserved). On fpu_out_valid_i: if fpu_tag_i[7:idx] == 0 and entry[idx].alloc && !done → store result/status, done=1. Otherwise drop and set tag_err_o.
- Writeback: wb_valid_o = entry[head].alloc && entry[head].done; wb_rd_o/wb_data_o from entry[head]. wb_valid_o held with stable data until wb_ready_i. On handshake: entry cleared, head++, fflags_o |= entry status.
- Latency: result capture to wb_valid_o is 1 cycle minimum (registered); issue to capture is FPU latency.
- Simultaneous events:
  - Issue, capture and retire in one cycle are all legal; when full, a retire does not open issue until the next cycle (full is registered-state based).
  - fflags_clr_i together with a retire: fflags_o <= retiring status (clear first, then OR).
  - Capture into the head entry while head is not done: wb_valid_o rises the next cycle.
- busy_o = !empty.

Optional Feature:
- Macro SNITCH_FPU_ROB_BYPASS_EN.
- Defined: when fpu_out_valid_i carries a valid tag equal to head and head is alloc && !done, wb_valid_o/wb_data_o/wb_rd_o forward the incoming result combinationally in the same cycle.
  - If wb_ready_i is also high, the entry retires directly: never marked done, status ORed into fflags, head++.
  - Otherwise the result is captured normally.
- Undefined: no bypass; minimum 1-cycle capture-to-writeback latency as above.

Test Plan:
- Reset, then issue rd=3 with fpu_in_ready_i=1 → fpu_tag_o=0, tail=1; return tag 0 result 0x3FF0000000000000 status 0 → next cycle wb_valid_o=1, wb_rd_o=3, data matches; after retire busy_o=0.
- Issue rd=1,2,3,4 (tags 0..3), fifth issue → issue_ready_o=0 and fpu_in_valid_o=0 while full. Return tags 3,1,0,2 → writebacks occur in order rd=1,2,3,4.
- Results with status 0x01 then 0x10 retired → fflags_o=0x11. Pulse fflags_clr_i in the same cycle as a retire with status 0x04 → fflags_o=0x04.
- Hold wb_ready_i=0 for 5 cycles with head done → wb_valid_o stays 1 and wb_data_o stable; meanwhile capture tags 1,2 → no retire until ready; then 3 back-to-back retires.
- Return fpu_tag_i=0x05 with NumEntries=4, or a duplicate tag 0 → tag_err_o=1 (sticky), ROB state unchanged.
- Tag wrap: 10 sequential issue/return pairs → tags cycle 0,1,2,3,0,… and all writebacks correct.
- With SNITCH_FPU_ROB_BYPASS_EN and wb_ready_i=1, return head tag → wb_valid_o=1 in the same cycle as fpu_out_valid_i.
- Assert rst_ni low with 2 ops in flight, then return tag 0 → tag_err_o=1, wb_valid_o=0.
